// File: rtl/tick_period_meter_pkg.sv
// Shared types and default constants for the tick period meter.
// The optional lock detector is enabled by defining TICK_PERIOD_METER_LOCK_EN.
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    localparam int unsigned DEF_MAX_PERIOD = 50000000;
    localparam int unsigned DEF_EXPECTED   = 50000000;
    localparam int unsigned DEF_TOL        = 16;
    localparam int unsigned DEF_LOCK_COUNT = 4;

    // Bits needed to hold a count of 0..max_value inclusive.
    function automatic int unsigned count_width(input int unsigned max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/tick_lock_filter.sv
// Tolerance compare plus saturating streak counter; lock asserts after
// LOCK_COUNT consecutive in-tolerance results and drops on any miss or clear.
module tick_lock_filter
    import tick_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned EXPECTED   = DEF_EXPECTED,
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] result,
    output logic             lock
);

    localparam int unsigned SW = count_width(LOCK_COUNT);
    localparam logic [SW-1:0] LC = SW'(LOCK_COUNT);
    localparam logic signed [WIDTH+1:0] EXP_S = (WIDTH+2)'(EXPECTED);
    localparam logic signed [WIDTH+1:0] TOL_S = (WIDTH+2)'(TOL);

    logic [SW-1:0]           streak_q, streak_d;
    logic                    lock_q, lock_d;
    logic signed [WIDTH+1:0] diff;
    logic signed [WIDTH+1:0] mag;
    logic                    in_tol;

    // Two guard bits keep the subtraction exact for any result/EXPECTED pair.
    always_comb begin
        diff   = $signed({2'b00, result}) - EXP_S;
        mag    = diff[WIDTH+1] ? -diff : diff;
        in_tol = (mag <= TOL_S);
    end

    always_comb begin
        streak_d = streak_q;
        lock_d   = lock_q;
        if (clear) begin
            streak_d = '0;
            lock_d   = 1'b0;
        end else if (result_valid) begin
            if (in_tol) begin
                streak_d = (streak_q == LC) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
            lock_d = (streak_d == LC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q <= '0;
            lock_q   <= 1'b0;
        end else begin
            streak_q <= streak_d;
            lock_q   <= lock_d;
        end
    end

    assign lock = lock_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between tick rising edges and reports them on a
// valid/ready output, with timeout/overrun flags; lock needs TICK_PERIOD_METER_LOCK_EN.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int unsigned MAX_PERIOD = DEF_MAX_PERIOD,
    parameter int unsigned EXPECTED   = DEF_EXPECTED,
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
    localparam int unsigned WIDTH     = $clog2(MAX_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             tick,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             lock,
    output logic             timeout,
    output logic             overrun,
    output state_e           state_dbg
);

    // Handshake: period is transferred on a cycle where period_valid and
    // period_ready are both high; period stays stable while valid and not ready.

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MAX_PERIOD - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_d_q;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    logic             tick_edge;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             lock_clear;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        overrun_d    = overrun_q;
        period_d     = period_q;
        valid_d      = valid_q;
        result_valid = 1'b0;
        lock_clear   = 1'b0;
        tick_edge    = tick & ~tick_d_q;
        result       = cnt_q + WIDTH'(1);

        if (!enable) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            timeout_d  = 1'b0;
            overrun_d  = 1'b0;
            lock_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_edge) begin
                        state_d = ST_MEASURE;
                        cnt_d   = '0;
                    end
                end
                ST_MEASURE: begin
                    if (tick_edge) begin
                        result_valid = 1'b1;
                        cnt_d        = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = ST_TIMEOUT;
                        cnt_d      = '0;
                        timeout_d  = 1'b1;
                        lock_clear = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                ST_TIMEOUT: begin
                    // The interval that timed out is meaningless, so no result.
                    if (tick_edge) begin
                        state_d   = ST_MEASURE;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A full slot is refilled only when the consumer takes it this cycle.
        if (result_valid) begin
            if (!valid_q || period_ready) begin
                period_d = result;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tick_d_q  <= 1'b0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tick_d_q  <= tick;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef TICK_PERIOD_METER_LOCK_EN
    tick_lock_filter #(
        .WIDTH      (WIDTH),
        .EXPECTED   (EXPECTED),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock_filter (
        .clk          (clk),
        .rst          (rst),
        .clear        (lock_clear),
        .result_valid (result_valid),
        .result       (result),
        .lock         (lock)
    );
`else
    localparam int unsigned unused_lock_cfg = EXPECTED + TOL + LOCK_COUNT;
    logic unused_lock_clear;
    assign unused_lock_clear = lock_clear;
    assign lock = 1'b0;
`endif

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;
    assign state_dbg    = state_q;

endmodule
